// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Data-hazard detection and forwarding-select generation for an
//            in-order pipeline. A shift-register scoreboard tracks producers
//            in the post-decode stages (stage 1 = EX ... stage DEPTH = WB) and
//            is compared against the sources of the instruction in decode.
//            Stall, forwarding selects and pipeline enables are combinational
//            from the scoreboard and the decode inputs.
//
// Parameters
//   XLEN      datapath width (sizes no port; range-checked only)
//   RAW       register address width
//   DEPTH     number of tracked post-decode stages, 2..8
//   LOAD_LAT  a load is forwardable from stage LOAD_LAT+1 on, 1..DEPTH-1
//
// Configuration macro
//   PIPE_HAZARD_FWD_EN  defined : forwarding enabled, stall only on
//                                 load-use hazards that forwarding cannot fix
//                       absent  : no forwarding, fwd_sel tied to 0, stall on
//                                 any producer in stages 1..DEPTH-1
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   i_id_valid              decode stage holds a real instruction
//   i_id_rs/_rt             source register addresses
//   i_id_uses_rs/_rt        instruction actually reads rs/rt
//   i_id_regwrite/_is_load  instruction writes a register / is a load
//   i_id_dest               destination register address
//   i_ex_branch_taken       branch resolved taken this cycle
//   o_fwd_sel_rs/_rt        0 = register file, k = forward from stage k
//   o_stall                 hold PC and IF/ID, bubble into stage 1
//   o_pc_write_en           PC update enable
//   o_if_id_write_en        IF/ID register enable
//   o_if_id_flush           IF/ID flush on taken branch
//   o_stall_cnt/_flush_cnt  saturating 16-bit event counters
//
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int RAW      = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_id_valid,
    input  logic [RAW-1:0]               i_id_rs,
    input  logic [RAW-1:0]               i_id_rt,
    input  logic                         i_id_uses_rs,
    input  logic                         i_id_uses_rt,
    input  logic                         i_id_regwrite,
    input  logic                         i_id_is_load,
    input  logic [RAW-1:0]               i_id_dest,
    input  logic                         i_ex_branch_taken,
    output logic [$clog2(DEPTH+1)-1:0]   o_fwd_sel_rs,
    output logic [$clog2(DEPTH+1)-1:0]   o_fwd_sel_rt,
    output logic                         o_stall,
    output logic                         o_pc_write_en,
    output logic                         o_if_id_write_en,
    output logic                         o_if_id_flush,
    output logic [15:0]                  o_stall_cnt,
    output logic [15:0]                  o_flush_cnt
);

    localparam int         SELW     = $clog2(DEPTH + 1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (XLEN < 1) begin : g_bad_xlen
        $error("pipe_hazard_unit: XLEN must be at least 1");
    end
    if ((DEPTH < 2) || (DEPTH > 8)) begin : g_bad_depth
        $error("pipe_hazard_unit: DEPTH must be in 2..8");
    end
    if ((LOAD_LAT < 1) || (LOAD_LAT > DEPTH - 1)) begin : g_bad_load_lat
        $error("pipe_hazard_unit: LOAD_LAT must be in 1..DEPTH-1");
    end

    // ------------------------------------------------------------------------
    // Scoreboard: one entry per post-decode stage, index 1 = youngest
    // ------------------------------------------------------------------------
    logic [DEPTH:1]  r_vld;
    logic [DEPTH:1]  r_wr;
    logic [DEPTH:1]  r_ld;
    logic [RAW-1:0]  r_dst [1:DEPTH];

    logic [15:0]     r_stall_cnt;
    logic [15:0]     r_flush_cnt;

    logic [DEPTH:1]  w_hit_rs;
    logic [DEPTH:1]  w_hit_rt;
    logic            w_need_stall;
    logic            w_stall;
    logic            w_issue;
    logic [SELW-1:0] w_sel_rs;
    logic [SELW-1:0] w_sel_rt;

    // Per-stage producer match for each source. Register 0 is hard-wired and
    // never a dependency, and an unused source field is ignored.
    always_comb begin
        w_hit_rs = '0;
        w_hit_rt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_hit_rs[k] = r_vld[k] && r_wr[k] && (r_dst[k] == i_id_rs) &&
                          (i_id_rs != '0) && i_id_uses_rs;
            w_hit_rt[k] = r_vld[k] && r_wr[k] && (r_dst[k] == i_id_rt) &&
                          (i_id_rt != '0) && i_id_uses_rt;
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    logic            w_yng_rs_ld;
    logic            w_yng_rt_ld;

    // Walk from oldest to youngest so the lowest matching stage overwrites
    // any older one: the youngest producer holds the architecturally newest
    // value. A load that is still too young to have its data cannot be
    // forwarded and turns into a stall.
    always_comb begin
        w_sel_rs    = '0;
        w_sel_rt    = '0;
        w_yng_rs_ld = 1'b0;
        w_yng_rt_ld = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_hit_rs[k]) begin
                w_sel_rs    = SELW'(k);
                w_yng_rs_ld = r_ld[k] && (k <= LOAD_LAT);
            end
            if (w_hit_rt[k]) begin
                w_sel_rt    = SELW'(k);
                w_yng_rt_ld = r_ld[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign w_need_stall = i_id_valid && (w_yng_rs_ld || w_yng_rt_ld);
`else
    // Without forwarding every in-flight producer blocks the consumer until
    // it reaches the last stage, where the register file writes before it is
    // read in the same cycle.
    logic w_unused_nofwd;

    assign w_sel_rs     = '0;
    assign w_sel_rt     = '0;
    assign w_need_stall = i_id_valid &&
                          ((|w_hit_rs[DEPTH-1:1]) || (|w_hit_rt[DEPTH-1:1]));
    assign w_unused_nofwd = ^{r_ld, w_hit_rs[DEPTH], w_hit_rt[DEPTH]};
`endif

    // A taken branch discards the decode instruction, so any stall it would
    // have caused is moot.
    assign w_stall = w_need_stall && !i_ex_branch_taken;
    assign w_issue = i_id_valid && !w_stall && !i_ex_branch_taken;

    assign o_stall          = w_stall;
    assign o_pc_write_en    = !w_stall;
    assign o_if_id_write_en = !w_stall;
    // Flush is suppressed while reset is held so the pipeline sees a clean
    // idle state regardless of what the branch unit drives.
    assign o_if_id_flush    = i_ex_branch_taken && rst_n;
    assign o_fwd_sel_rs     = w_stall ? '0 : w_sel_rs;
    assign o_fwd_sel_rt     = w_stall ? '0 : w_sel_rt;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_flush_cnt      = r_flush_cnt;

    // ------------------------------------------------------------------------
    // Scoreboard shift: new decode fields or a bubble enter stage 1, every
    // other entry advances one stage, the last entry retires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wr  <= '0;
            r_ld  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dst[k] <= '0;
            end
        end else begin
            r_vld[1] <= w_issue;
            r_wr[1]  <= w_issue && i_id_regwrite;
            r_ld[1]  <= w_issue && i_id_is_load;
            r_dst[1] <= w_issue ? i_id_dest : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_wr[k]  <= r_wr[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (o_if_id_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Directed-vector bench for pipe_hazard_unit (DEPTH=3,
//            LOAD_LAT=1), expected values hand-computed for the build
//            selected by PIPE_HAZARD_FWD_EN. A second instance (DEPTH=8,
//            LOAD_LAT=7) is kept in a near-permanent stall to drive the stall
//            counter into saturation while the main instance saturates its
//            flush counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int NSAT = 76000;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_is_load, br;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [1:0]  fwd_rs, fwd_rt;
    logic        stall, pcwe, ifwe, flush;
    logic [15:0] scnt, fcnt;

    // Saturation instance: fixed "writes r3 and reads r3" load in decode
    logic        s_valid, s_uses_rs, s_uses_rt, s_regwrite, s_is_load, s_br;
    logic [4:0]  s_rs, s_rt, s_dest;
    logic [3:0]  sat_unused_frs, sat_unused_frt;
    logic        sat_unused_stall, sat_unused_pcwe, sat_unused_ifwe, sat_unused_flush;
    logic [15:0] sat_scnt, sat_unused_fcnt;

    pipe_hazard_unit #(.XLEN(32), .RAW(5), .DEPTH(3), .LOAD_LAT(1)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_id_valid        (id_valid),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_uses_rs      (id_uses_rs),
        .i_id_uses_rt      (id_uses_rt),
        .i_id_regwrite     (id_regwrite),
        .i_id_is_load      (id_is_load),
        .i_id_dest         (id_dest),
        .i_ex_branch_taken (br),
        .o_fwd_sel_rs      (fwd_rs),
        .o_fwd_sel_rt      (fwd_rt),
        .o_stall           (stall),
        .o_pc_write_en     (pcwe),
        .o_if_id_write_en  (ifwe),
        .o_if_id_flush     (flush),
        .o_stall_cnt       (scnt),
        .o_flush_cnt       (fcnt)
    );

    pipe_hazard_unit #(.XLEN(32), .RAW(5), .DEPTH(8), .LOAD_LAT(7)) u_sat (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_id_valid        (s_valid),
        .i_id_rs           (s_rs),
        .i_id_rt           (s_rt),
        .i_id_uses_rs      (s_uses_rs),
        .i_id_uses_rt      (s_uses_rt),
        .i_id_regwrite     (s_regwrite),
        .i_id_is_load      (s_is_load),
        .i_id_dest         (s_dest),
        .i_ex_branch_taken (s_br),
        .o_fwd_sel_rs      (sat_unused_frs),
        .o_fwd_sel_rt      (sat_unused_frt),
        .o_stall           (sat_unused_stall),
        .o_pc_write_en     (sat_unused_pcwe),
        .o_if_id_write_en  (sat_unused_ifwe),
        .o_if_id_flush     (sat_unused_flush),
        .o_stall_cnt       (sat_scnt),
        .o_flush_cnt       (sat_unused_fcnt)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        st;
        logic [1:0]  frs;
        logic [1:0]  frt;
        logic        cf;      // compare forwarding selects
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        chk_sat;
        logic [15:0] sat_sc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic next_chk_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            cur = q.pop_front();
            check({cur.name, ".stale"}, 16'(cur.cyc), 16'(cyc));
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            cur = q.pop_front();
            check({cur.name, ".stall"},   16'(stall), 16'(cur.st));
            check({cur.name, ".pc_we"},   16'(pcwe),  16'(!cur.st));
            check({cur.name, ".ifid_we"}, 16'(ifwe),  16'(!cur.st));
            check({cur.name, ".flush"},   16'(flush), 16'(cur.fl));
            check({cur.name, ".stall_cnt"}, scnt, cur.sc);
            check({cur.name, ".flush_cnt"}, fcnt, cur.fc);
            if (cur.cf) begin
                check({cur.name, ".fwd_rs"}, 16'(fwd_rs), 16'(cur.frs));
                check({cur.name, ".fwd_rt"}, 16'(fwd_rt), 16'(cur.frt));
            end
            if (cur.chk_sat) begin
                check({cur.name, ".sat_stall_cnt"}, sat_scnt, cur.sat_sc);
            end
        end
    end

    // Drive one decode cycle and queue the expected combinational response.
    task automatic step(input string nm, input int v, input int rs, input int urs,
                        input int rt, input int urt, input int rw, input int ld,
                        input int dst, input int b, input int e_st, input int e_frs,
                        input int e_frt, input int e_cf, input int e_fl,
                        input int e_sc, input int e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid    = v[0];
        id_rs       = rs[4:0];
        id_uses_rs  = urs[0];
        id_rt       = rt[4:0];
        id_uses_rt  = urt[0];
        id_regwrite = rw[0];
        id_is_load  = ld[0];
        id_dest     = dst[4:0];
        br          = b[0];
        e.name    = nm;
        e.cyc     = cyc;
        e.st      = e_st[0];
        e.frs     = e_frs[1:0];
        e.frt     = e_frt[1:0];
        e.cf      = e_cf[0];
        e.fl      = e_fl[0];
        e.sc      = e_sc[15:0];
        e.fc      = e_fc[15:0];
        e.chk_sat = next_chk_sat;
        e.sat_sc  = 16'hFFFF;
        q.push_back(e);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_regwrite = 1'b0; id_is_load = 1'b0; id_dest = '0; br = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        s_valid = 1'b1; s_rs = 5'd3; s_uses_rs = 1'b1; s_rt = 5'd0; s_uses_rt = 1'b0;
        s_regwrite = 1'b1; s_is_load = 1'b1; s_dest = 5'd3; s_br = 1'b0;

        // Reset held with a taken branch and a would-be hazard on the inputs
        //    name  v rs u rt u rw ld ds br | st frs frt cf fl sc fc
        step("reset", 1, 3, 1, 3, 1, 1, 1, 3, 1,  0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        idle();
        rst_n = 1'b1;

`ifdef PIPE_HAZARD_FWD_EN
        step("add_r3",     1, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0, 0, 1, 0, 0, 0);
        step("fwd_s1",     1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0);
        step("fwd_s2",     1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, 0, 0);
        step("lw_r5",      1, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 1, 0, 0, 0);
        step("ld_use",     1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        step("ld_fwd",     1, 0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 2, 1, 0, 1, 0);
        step("lw_r5b",     1, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 1, 0, 1, 0);
        step("flush_wins", 1, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0);
        step("post_flush", 1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, 1, 1);
        step("wr_r0",      1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1);
        step("rd_r0",      1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1);
        step("add_r7a",    1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 1, 0, 1, 1);
        step("add_r7b",    1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 1, 0, 1, 1);
        step("rd_r7",      1, 7, 1, 7, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0, 1, 1);
        step("lw_r9",      1, 0, 0, 0, 0, 1, 1, 9, 0,  0, 0, 0, 1, 0, 1, 1);
        step("inv_nostall",0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
        step("fwd_s2_r9",  1, 9, 1, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, 1, 1);
        step("fwd_s3_r9",  1, 9, 1, 0, 0, 0, 0, 0, 0,  0, 3, 0, 1, 0, 1, 1);
        step("lw_r4",      1, 0, 0, 0, 0, 1, 1, 4, 0,  0, 0, 0, 1, 0, 1, 1);
        step("ld_use_r4",  1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 1);
`else
        step("add_r3",     1, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0, 0, 1, 0, 0, 0);
        step("stall_s1",   1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        step("stall_s2",   1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0);
        step("rf_s3",      1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 0);
        step("lw_r5",      1, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 1, 0, 2, 0);
        step("flush_wins", 1, 0, 0, 5, 1, 0, 0, 0, 1,  0, 0, 0, 1, 1, 2, 0);
        step("ld_stall_s2",1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 2, 1);
        step("ld_rf_s3",   1, 0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3, 1);
        step("wr_r0",      1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 3, 1);
        step("rd_r0",      1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3, 1);
        step("add_r7a",    1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 1, 0, 3, 1);
        step("add_r7b",    1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 1, 0, 3, 1);
        step("rd_r7_s1",   1, 7, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 3, 1);
        step("rd_r7_s2",   1, 7, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 4, 1);
        step("rd_r7_s3",   1, 7, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 5, 1);
        step("lw_r9",      1, 0, 0, 0, 0, 1, 1, 9, 0,  0, 0, 0, 1, 0, 5, 1);
        step("inv_nostall",0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 5, 1);
        step("lw_r4",      1, 0, 0, 0, 0, 1, 1, 4, 0,  0, 0, 0, 1, 0, 5, 1);
        step("stall_r4",   1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 5, 1);
`endif
        // Asynchronous reset between clock edges: everything idle at once
        step("rst_mid",    1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        step("rst_hold",   1, 4, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
        step("after_rst",  1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        rst_n = 1'b1;

        // Continuous taken branches saturate the flush counter; the second
        // instance stalls 7 of every 8 cycles in the meantime.
        step("sat_start",  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0);
        repeat (NSAT) @(posedge clk);
        next_chk_sat = 1'b1;
        step("sat_end",    0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 16'hFFFF);
        next_chk_sat = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width; sizes no ports, fixed by downstream forwarding muxes.
REQ-002 Parameter RAW, default 5: register address width.
REQ-003 Parameter DEPTH, default 3: number of post-decode stages tracked (stage 1 = EX ... stage DEPTH = WB); legal range 2..8.
REQ-004 Parameter LOAD_LAT, default 1: a load's data is forwardable only from stage LOAD_LAT+1 onward; legal range 1..DEPTH-1.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  decode stage holds a real instruction.
REQ-008 id_rs, id_rt  in  RAW each  source register addresses.
REQ-009 id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt.
REQ-010 id_regwrite, id_is_load  in  1 each  instruction writes a register / is a load.
REQ-011 id_dest  in  RAW  destination register address.
REQ-012 ex_branch_taken  in  1  branch resolved taken this cycle.
REQ-013 fwd_sel_rs, fwd_sel_rt  out  clog2(DEPTH+1) each  0 = register file, k = forward from stage k.
REQ-014 stall, pc_write_en, if_id_write_en, if_id_flush  out  1 each  pipeline control.
REQ-015 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-016 Scoreboard: DEPTH entries {valid, regwrite, is_load, dest}; every rising CLK entry[k+1] <= entry[k] for k = 1..DEPTH-1; entry[DEPTH] retires.
REQ-017 entry[1] <= ID fields when id_valid && !stall && !ex_branch_taken; otherwise entry[1] <= bubble (valid=0).
REQ-018 Match at stage k for a source: entry[k].valid && entry[k].regwrite && entry[k].dest == src && src != 0 && source used.
REQ-019 Youngest match (lowest k) wins; fwd_sel = that k, else 0.
REQ-020 Load-use stall: youngest match is a load with k <= LOAD_LAT, for either source, while id_valid.
REQ-021 stall, fwd_sel and control outputs are combinational from scoreboard and ID inputs (zero-cycle latency); fwd_sel = 0 whenever stall = 1.
REQ-022 stall=1 -> pc_write_en=0, if_id_write_en=0, bubble into stage 1.
REQ-023 ex_branch_taken=1 -> if_id_flush=1, pc_write_en=1, if_id_write_en=1, stall forced 0, bubble into stage 1 (flush wins over stall in same cycle).
REQ-024 Otherwise pc_write_en=1, if_id_write_en=1, if_id_flush=0.
REQ-025 stall_cnt increments each cycle stall=1; flush_cnt increments each cycle if_id_flush=1; both saturate at 16'hFFFF, never wrap.
REQ-026 Register 0 never produces a match; id_valid=0 never stalls.

Reset
REQ-027 RST_N low asynchronously clears all scoreboard entries to invalid and both counters to 0, including mid-stall or mid-flush.
REQ-028 During and after reset until new entries arrive: stall=0, if_id_flush=0, pc_write_en=1, if_id_write_en=1, fwd_sel=0.

Configuration
REQ-029 Macro PIPE_HAZARD_FWD_EN defined: forwarding per REQ-019/020.
REQ-030 Macro absent: fwd_sel tied to 0; stall whenever any match exists in stages 1..DEPTH-1 (stage DEPTH covered by write-before-read register file), loads and ALU ops alike.

Verification (DEPTH=3, LOAD_LAT=1, PIPE_HAZARD_FWD_EN defined unless noted)
REQ-031 ADD r3 issued, next cycle ID reads rs=r3 -> fwd_sel_rs=1, stall=0; one cycle later fwd_sel_rs=2.
REQ-032 LW r5 issued, next cycle ID reads rt=r5 -> stall=1 one cycle, pc_write_en=0, stall_cnt=1; following cycle stall=0, fwd_sel_rt=2.
REQ-033 LW r5 pending stall and ex_branch_taken=1 same cycle -> stall=0, if_id_flush=1, pc_write_en=1, flush_cnt=1, stage 1 bubble.
REQ-034 Producer writes r0, consumer reads r0 -> fwd_sel=0, stall=0; producers r7 in stages 1 and 2, consumer reads r7 -> fwd_sel=1.
REQ-035 Macro absent: ADD r3 then consumer of r3 -> stall=1 for 2 cycles, fwd_sel=0 throughout; hold stall 70000 cycles -> stall_cnt=16'hFFFF.
REQ-036 Assert RST_N=0 mid-stall -> stall=0, counters 0, scoreboard empty immediately, without CLK edge.
